fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//   Parametrised single-clock FIFO: configurable width/depth, true full at DEPTH entries,
//   occupancy count, programmable almost-full/almost-empty flags, guarded push/pop.
//   Show-ahead read: out always presents the oldest entry. Generic inter-stage buffer.
// PARAMETERS
//   WIDTH      8   data width in bits (>=1)
//   DEPTH      8   entries; power of two, >=2
//   AF_LEVEL   6   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL   2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//   clk           in   1         clock, rising edge
//   rst           in   1         reset, asynchronous assert, active-low
//   in            in   WIDTH     write data
//   we            in   1         push request
//   full          out  1         count == DEPTH
//   almost_full   out  1         count >= AF_LEVEL
//   out           out  WIDTH     head-of-queue data, valid when !empty
//   re            in   1         pop request
//   empty         out  1         count == 0
//   almost_empty  out  1         count <= AE_LEVEL
//   count         out  CW        occupancy, CW = $clog2(DEPTH+1)
// BEHAVIOUR
//   - Pointers head/tail are AW+1 bits (AW=$clog2(DEPTH)); MSB is wrap bit.
//     empty: head==tail. full: addr bits equal, wrap bits differ. No lost slot.
//   - rst low (async): head=tail=0, count=0, empty=1, almost_empty=1, full=0,
//     almost_full=0. Memory not reset; out undefined while empty.
//   - push_ok = we & (!full | re); pop_ok = re & !empty. Evaluated on pre-edge state.
//   - push_ok: mem[head[AW-1:0]] <= in, head++. pop_ok: tail++.
//   - count: +1 push only, -1 pop only, unchanged both/neither. Registered.
//   - All flags derived from registered pointers/count; update 1 cycle after the edge.
//   - Read latency 0: out = mem[tail[AW-1:0]] combinationally; after pop, next entry
//     visible after the edge. Write-to-out latency 1 cycle (written on edge N, visible
//     after edge N when empty).
//   - full & we & re: both accepted, count stays DEPTH, full stays 1.
//   - empty & we & re: pop ignored, push accepted, count -> 1. No bypass.
//   - we while full, no re: dropped, state unchanged. re while empty: ignored.
//   - Pointer wrap: natural modulo 2^(AW+1) rollover, no special case.
//   - rst asserted mid-operation: contents discarded immediately, flags to reset values.
// CONFIGURATION
//   FIFO_SYNC_ERR_EN defined: add outputs overflow, underflow (1 bit each). Sticky;
//     overflow set on we&full&!re, underflow set on re&empty; cleared only by rst.
//     Reset value 0.
//   Not defined: ports absent; dropped requests silent. Core behaviour identical.
// STRUCTURE
//   fifo_pkg: function clog2-based width helpers, typedef ptr_t/cnt_t builders are
//     per-instance localparams; package holds FIFO_PTR_WRAP_BIT helper and shared
//     status struct fifo_status_t {full, almost_full, empty, almost_empty}.
//   Sub-module fifo_ram: DEPTH x WIDTH array, sync write port, async read port.
//   Top holds pointers, count, flags, optional error logic.
// TESTING
//   1 Reset: rst=0 mid-stream after 3 pushes -> empty=1, count=0, full=0 next sample.
//   2 Fill: DEPTH=8, push 0x01..0x08 -> full=1 at count 8, almost_full from count 6;
//     9th push 0xFF dropped; pop 8 -> out 0x01..0x08 in order, empty=1.
//   3 Wrap: push/pop 20 items interleaved 3-push/2-pop -> output order exact,
//     count matches model each cycle.
//   4 Simultaneous at full: we=re=1, in=0xAA -> out advances, count stays 8,
//     0xAA appears as 8th-later pop.
//   5 Simultaneous at empty: we=re=1, in=0x5A -> count=1, out=0x5A next cycle.
//   6 FIFO_SYNC_ERR_EN: push when full -> overflow=1 sticky; pop when empty ->
//     underflow=1; both clear only on rst.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg : shared pointer-width helper and status flag bundle      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fifo_pkg;

  // Bit index of the wrap bit for a DEPTH-entry pointer (also the address width).
  function automatic int FIFO_PTR_WRAP_BIT(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_ram : DEPTH x WIDTH storage, synchronous write, async read    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_sync_param : single-clock show-ahead FIFO with level flags;   |
// | FIFO_SYNC_ERR_EN adds sticky overflow/underflow outputs. Rev 1.0   |
// +--------------------------------------------------------------------+
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = 6,
  parameter  int AE_LEVEL = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             we,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH-1:0] out,
  input  logic             re,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count
`ifdef FIFO_SYNC_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int          AW   = FIFO_PTR_WRAP_BIT(DEPTH);
  localparam logic [CW-1:0] c_AF = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_AE = CW'(AE_LEVEL);

  logic [AW:0]   r_head;
  logic [AW:0]   r_tail;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  fifo_status_t  w_status;

  // Wrap bit distinguishes full from empty when the address bits coincide.
  assign w_status.empty        = (r_head == r_tail);
  assign w_status.full         = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);
  assign w_status.almost_full  = (r_count >= c_AF);
  assign w_status.almost_empty = (r_count <= c_AE);

  assign w_push = we && (!w_status.full || re);
  assign w_pop  = re && !w_status.empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_head <= r_head + 1'b1;
      if (w_pop)  r_tail <= r_tail + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_head[AW-1:0]),
    .i_wdata (in),
    .i_raddr (r_tail[AW-1:0]),
    .o_rdata (out)
  );

  assign full         = w_status.full;
  assign almost_full  = w_status.almost_full;
  assign empty        = w_status.empty;
  assign almost_empty = w_status.almost_empty;
  assign count        = r_count;

`ifdef FIFO_SYNC_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (we && w_status.full && !re) r_overflow  <= 1'b1;
      if (re && w_status.empty)       r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_sync_param : table, directed and random checks vs queue    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fifo_sync_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             we  = 1'b0;
  logic             re  = 1'b0;
  logic             full, almost_full, empty, almost_empty;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    cnt;
`ifdef FIFO_SYNC_ERR_EN
  logic             ovf, udf;
`endif

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .we(we), .full(full),
    .almost_full(almost_full), .out(dout), .re(re), .empty(empty),
    .almost_empty(almost_empty), .count(cnt)
`ifdef FIFO_SYNC_ERR_EN
    , .overflow(ovf), .underflow(udf)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] q[$];
  bit m_ovf = 0;
  bit m_udf = 0;

  typedef struct {
    bit         we;
    bit         re;
    logic [7:0] din;
    int         exp_count;
    bit         exp_empty;
    bit         exp_full;
    bit         exp_af;
    bit         exp_ae;
    logic [7:0] exp_out;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(cnt), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    if (q.size() != 0) chk("out", 32'(dout), 32'(q[0]));
`ifdef FIFO_SYNC_ERR_EN
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(udf), 32'(m_udf));
`endif
  endtask

  // One clock: drive request at posedge+1, model the edge, compare at next posedge+1.
  task automatic step(input bit w, input bit r, input logic [7:0] d);
    bit push_ok, pop_ok;
    we = w; re = r; din = d;
    push_ok = w && (q.size() < DEPTH || r);
    pop_ok  = r && (q.size() != 0);
    if (w && q.size() == DEPTH && !r) m_ovf = 1;
    if (r && q.size() == 0) m_udf = 1;
    @(posedge clk);
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    #1;
    we = 0; re = 0;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    q.delete(); m_ovf = 0; m_udf = 0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_seq[$];
    int pushed;
    // Fill table: 8 pushes, dropped 9th, then 8 pops in order.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{1, 0, 8'(i + 1), i + 1, 0, (i + 1 == 8), (i + 1 >= 6), (i + 1 <= 2), 8'h01};
    end
    tbl[8] = '{1, 0, 8'hFF, 8, 0, 1, 1, 0, 8'h01};
    for (int i = 0; i < 8; i++) begin
      tbl[9 + i] = '{0, 1, 8'h00, 7 - i, (i == 7), 0, (7 - i >= 6), (7 - i <= 2), 8'(i + 2)};
    end

    #2;
    do_reset();

    // Reset mid-stream after 3 pushes.
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
    @(negedge clk);
    do_reset();

    // Fill / drain via table.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].din);
      chk($sformatf("tbl%0d_count", i), 32'(cnt), 32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
      chk($sformatf("tbl%0d_af", i), 32'(almost_full), 32'(tbl[i].exp_af));
      chk($sformatf("tbl%0d_ae", i), 32'(almost_empty), 32'(tbl[i].exp_ae));
      if (!tbl[i].exp_empty) chk($sformatf("tbl%0d_out", i), 32'(dout), 32'(tbl[i].exp_out));
    end

    // Extra pop while empty (underflow when enabled).
    step(0, 1, 8'h00);

    // Wrap: 20 items, 3-push / 2-pop interleave, exact output order.
    do_reset();
    pushed = 0;
    exp_seq.delete();
    while (pushed < 20 || q.size() != 0) begin
      for (int k = 0; k < 3 && pushed < 20; k++) begin
        step(1, 0, 8'(8'h40 + pushed));
        pushed++;
      end
      for (int k = 0; k < 2 && q.size() != 0; k++) begin
        exp_seq.push_back(dout);
        step(0, 1, 8'h00);
      end
    end
    for (int i = 0; i < 20; i++) chk("wrap_order", 32'(exp_seq[i]), 32'(8'h40 + i));

    // Simultaneous push/pop at full.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hC0 + i));
    step(1, 1, 8'hAA);
    chk("full_both_count", 32'(cnt), 32'd8);
    chk("full_both_full", 32'(full), 32'd1);
    chk("full_both_out", 32'(dout), 32'hC1);
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00);
    chk("full_both_aa", 32'(dout), 32'hAA);
    step(0, 1, 8'h00);
    chk("full_both_drain", 32'(empty), 32'd1);

    // Simultaneous push/pop at empty.
    step(1, 1, 8'h5A);
    chk("empty_both_count", 32'(cnt), 32'd1);
    chk("empty_both_out", 32'(dout), 32'h5A);
    step(0, 1, 8'h00);

`ifdef FIFO_SYNC_ERR_EN
    do_reset();
    chk("ovf_reset", 32'(ovf), 32'd0);
    chk("udf_reset", 32'(udf), 32'd0);
    for (int i = 0; i < 9; i++) step(1, 0, 8'(i));
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int i = 0; i < 9; i++) step(0, 1, 8'h00);
    chk("udf_set", 32'(udf), 32'd1);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    do_reset();
    chk("ovf_clear", 32'(ovf), 32'd0);
    chk("udf_clear", 32'(udf), 32'd0);
`endif

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      if (i == 200) begin
        @(negedge clk);
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
